// File: rtl/alu_dispatch_unit_pkg.sv
// alu_dispatch_unit_pkg
// Shared definitions for the ALU dispatch unit: function codes, the default
// latency vector for the standard four-unit configuration, and the per-unit
// tracker state type.
package alu_dispatch_unit_pkg;

  // Function unit codes.
  localparam int unsigned FUN_ARITH = 0;
  localparam int unsigned FUN_LOGIC = 1;
  localparam int unsigned FUN_CMP   = 2;
  localparam int unsigned FUN_SHIFT = 3;

  // Default latency vector for four units with 3-bit latency fields (all single-cycle).
  localparam logic [11:0] DEFAULT_UNIT_LAT = {4{3'd1}};

  typedef enum logic {
    StIdle,
    StBusy
  } unit_state_e;

endpackage

// File: rtl/unit_busy_tracker.sv
// unit_busy_tracker
// One function unit's IDLE/BUSY machine with a latency down-counter.
// Ports:
//   CLK    - clock, rising edge
//   RST    - synchronous active-high reset
//   Issue  - accept decoded for this unit this cycle
//   Lat    - configured latency (0 is treated as 1)
//   Enable - registered one-cycle issue pulse
//   Busy   - registered, unit occupied
//   Done   - registered one-cycle completion pulse (cycle where count == 1)
module unit_busy_tracker
  import alu_dispatch_unit_pkg::*;
#(
  parameter int unsigned LAT_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Issue,
  input  logic [LAT_WIDTH-1:0] Lat,
  output logic                 Enable,
  output logic                 Busy,
  output logic                 Done
);

  unit_state_e          r_state;
  logic [LAT_WIDTH-1:0] r_cnt;
  logic [LAT_WIDTH-1:0] w_lat_eff;

  assign w_lat_eff = (Lat == '0) ? LAT_WIDTH'(1) : Lat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      Enable  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Enable <= 1'b0;
      Done   <= 1'b0;
      if (Issue) begin
        // Issue is only offered when idle or in the done cycle, so a reload is always safe.
        r_state <= StBusy;
        r_cnt   <= w_lat_eff;
        Enable  <= 1'b1;
        Busy    <= 1'b1;
        Done    <= (w_lat_eff == LAT_WIDTH'(1));
      end else begin
        unique case (r_state)
          StIdle: begin
            r_cnt <= '0;
            Busy  <= 1'b0;
          end
          StBusy: begin
            if (r_cnt <= LAT_WIDTH'(1)) begin
              r_state <= StIdle;
              r_cnt   <= '0;
              Busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt - LAT_WIDTH'(1);
              // Done is registered, so raise it on the edge where the count reaches 1.
              Done  <= (r_cnt == LAT_WIDTH'(2));
            end
          end
          default: begin
            r_state <= StIdle;
            r_cnt   <= '0;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_dispatch_unit.sv
// alu_dispatch_unit
// Accepts an operation code under valid/ready and issues a one-cycle enable to
// the selected function unit, tracking per-unit busy state and completion.
// Ports:
//   CLK, RST    - clock and synchronous active-high reset
//   ALU_FUN     - operation code, stable while OP_Valid is high
//   OP_Valid    - operation offered
//   OP_Ready    - combinational; accept when OP_Valid & OP_Ready at a rising edge
//   Unit_Enable - registered one-hot issue pulse
//   Unit_Busy   - registered per-unit occupancy
//   Unit_Done   - registered per-unit completion pulse
//   Illegal_Op  - registered pulse for an accepted out-of-range code
//   Last_Fun    - registered code of the most recent accept
module alu_dispatch_unit
  import alu_dispatch_unit_pkg::*;
#(
  parameter int unsigned                       FUN_WIDTH = 2,
  parameter int unsigned                       NUM_UNITS = 4,
  parameter int unsigned                       LAT_WIDTH = 3,
  parameter logic [NUM_UNITS*LAT_WIDTH-1:0]    UNIT_LAT  = {NUM_UNITS{LAT_WIDTH'(1)}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [FUN_WIDTH-1:0] ALU_FUN,
  input  logic                 OP_Valid,
  output logic                 OP_Ready,
  output logic [NUM_UNITS-1:0] Unit_Enable,
  output logic [NUM_UNITS-1:0] Unit_Busy,
  output logic [NUM_UNITS-1:0] Unit_Done,
  output logic                 Illegal_Op,
  output logic [FUN_WIDTH-1:0] Last_Fun
);

  logic [NUM_UNITS-1:0] w_hit;
  logic                 w_legal;
  logic                 w_accept;

  // Decode the code against each unit; out-of-range codes hit nothing and are always ready.
  always_comb begin
    w_hit    = '0;
    OP_Ready = 1'b1;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (ALU_FUN == FUN_WIDTH'(k)) begin
        w_hit[k] = 1'b1;
        // Ready again in the done cycle, allowing back-to-back issue.
        OP_Ready = ~Unit_Busy[k] | Unit_Done[k];
      end
    end
  end

  assign w_legal  = |w_hit;
  assign w_accept = OP_Valid & OP_Ready & ~RST;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    unit_busy_tracker #(
      .LAT_WIDTH(LAT_WIDTH)
    ) u_tracker (
      .CLK   (CLK),
      .RST   (RST),
      .Issue (w_accept & w_hit[g]),
      .Lat   (UNIT_LAT[g*LAT_WIDTH +: LAT_WIDTH]),
      .Enable(Unit_Enable[g]),
      .Busy  (Unit_Busy[g]),
      .Done  (Unit_Done[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Illegal_Op <= 1'b0;
      Last_Fun   <= '0;
    end else begin
      Illegal_Op <= w_accept & ~w_legal;
      if (w_accept) begin
        Last_Fun <= ALU_FUN;
      end
    end
  end

endmodule
